// File: rtl/fp_if_pkg.sv
// ----------------------------------------------------------------------------
// fp_if_pkg
// Shared definitions for the floating-point add/sub unit interface:
//   state_t  - sequencer states of the unit driver
//   FP_W     - IEEE-754 single-precision word width
//   OP_ADD / OP_SUB - encoding of the op signal (0 = a+b, 1 = a-b)
// ----------------------------------------------------------------------------
package fp_if_pkg;

   localparam int   FP_W   = 32;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } state_t;

endpackage

// File: rtl/fp_wdog_counter.sv
// ----------------------------------------------------------------------------
// fp_wdog_counter
// Watchdog cycle counter for the add/sub driver. Counts enabled cycles and
// flags the terminal count TIMEOUT_CYCLES-1.
// Ports:
//   clock    - system clock
//   reset    - synchronous, active-low reset
//   clear    - synchronous clear (wins over enable)
//   enable   - count this cycle
//   count    - current count value
//   tc       - count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module fp_wdog_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              enable,
   output logic [$clog2(TIMEOUT_CYCLES)-1:0] count,
   output logic                              tc
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   // NOTE: reset is sampled inside the clocked block, so it is synchronous;
   // putting it in the sensitivity list would make it asynchronous.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fp_addsub_driver.sv
// ----------------------------------------------------------------------------
// fp_addsub_driver
// Sequencer for the floating-point add/sub unit (start/op/busy/ready style).
// Takes one operand pair at a time from a valid/ready stream, launches it with
// a one-cycle start pulse, holds operands stable, captures the one-cycle
// result strobe and returns the result with its tag on a valid/ready stream.
// A watchdog turns a missing result strobe into a flagged timeout result.
// Ports:
//   clock, reset                    - clock, synchronous active-low reset
//   in_valid/in_ready               - operand stream handshake
//   in_op, in_a, in_b, in_tag       - op (0 add, 1 sub), operands, user tag
//   out_valid/out_ready             - result stream handshake
//   out_data, out_tag, out_timeout  - result (0 on timeout), tag, timeout flag
//   fpu_start, fpu_op               - start pulse and op to the unit
//   fpu_data_a, fpu_data_b          - operands to the unit
//   fpu_busy                        - unit busy (debug observation only)
//   fpu_ready, fpu_data_o           - unit result strobe and result
// ----------------------------------------------------------------------------
module fp_addsub_driver
   import fp_if_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,   // must be >= 8
   parameter int TAG_W          = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [FP_W-1:0]  in_a,
   input  logic [FP_W-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_timeout,
   output logic             fpu_start,
   output logic             fpu_op,
   output logic [FP_W-1:0]  fpu_data_a,
   output logic [FP_W-1:0]  fpu_data_b,
   input  logic             fpu_busy,
   input  logic             fpu_ready,
   input  logic [FP_W-1:0]  fpu_data_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] wdog;
   logic             wdog_tc;

   // Debug-only sticky flag: the unit had not raised busy two cycles after
   // ISSUE. Nothing in the control path reads it.
   logic             unused_busy_late;

   // Cleared while in ISSUE, so the first WAIT cycle sees a count of zero.
   fp_wdog_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clock  (clock),
      .reset  (reset),
      .clear  (state == ISSUE),
      .enable (state == WAIT),
      .count  (wdog),
      .tc     (wdog_tc)
   );

   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; blocking assignments would make the
   // result depend on statement order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state            <= IDLE;
         in_ready         <= 1'b0;
         out_valid        <= 1'b0;
         out_data         <= '0;
         out_tag          <= '0;
         out_timeout      <= 1'b0;
         fpu_start        <= 1'b0;
         fpu_op           <= 1'b0;
         fpu_data_a       <= '0;
         fpu_data_b       <= '0;
         unused_busy_late <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // Operands, op and tag are frozen here until the result
                  // has been handed downstream.
                  fpu_data_a <= in_a;
                  fpu_data_b <= in_b;
                  fpu_op     <= in_op;
                  out_tag    <= in_tag;
                  fpu_start  <= 1'b1;
                  in_ready   <= 1'b0;
                  state      <= ISSUE;
               end else begin
                  in_ready   <= 1'b1;
               end
            end

            ISSUE: begin
               fpu_start <= 1'b0;
               state     <= WAIT;
            end

            WAIT: begin
               // A late busy is only recorded; fpu_ready alone ends the wait.
               if (wdog == CNT_W'(1) && !fpu_busy) begin
                  unused_busy_late <= 1'b1;
               end
               // The result strobe wins over a watchdog expiry in the same cycle.
               if (fpu_ready) begin
                  out_data    <= fpu_data_o;
                  out_timeout <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= HOLD;
               end else if (wdog_tc) begin
                  out_data    <= '0;
                  out_timeout <= 1'b1;
                  out_valid   <= 1'b1;
                  state       <= HOLD;
               end
            end

            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
